// File: rtl/rw_seq_pkg.sv
// Shared types and defaults for the read/write port sequencer.
package rw_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        WAIT = 2'd3
    } state_t;

    typedef enum logic {
        SIDE_RD = 1'b0,
        SIDE_WR = 1'b1
    } side_t;

    localparam int unsigned DEFAULT_TIMEOUT = 8;

endpackage

// File: rtl/rw_port_sequencer.sv
// Round-robin sequencer for a single-port resource with separate read/write
// strobes; writes wait for ready and raise a sticky timeout error if it never comes.
module rw_port_sequencer
    import rw_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic resetn,
    input  logic rd_req,
    output logic rd_gnt,
    output logic rd_done,
    input  logic wr_req,
    output logic wr_gnt,
    output logic wr_done,
    output logic read,
    output logic write,
    input  logic ready,
    input  logic err_clr,
    output logic timeout_err,
    output logic busy
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t         state;
    state_t         state_nxt;
    side_t          last_grant;
    side_t          last_grant_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic           err_set;

    // State, arbitration history, wait counter and sticky error.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            last_grant  <= SIDE_WR;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
            if (err_set) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    // Next-state, round-robin decision and wait-phase handling.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        err_set        = 1'b0;
        wr_done        = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req && (!wr_req || (last_grant == SIDE_WR))) begin
                    state_nxt      = RD;
                    last_grant_nxt = SIDE_RD;
                end else if (wr_req) begin
                    state_nxt      = WR;
                    last_grant_nxt = SIDE_WR;
                end
            end
            RD: begin
                state_nxt = IDLE;
            end
            WR: begin
                state_nxt = WAIT;
                cnt_nxt   = '0;
            end
            WAIT: begin
                if (ready) begin
                    wr_done   = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes and handshakes decode from the state register only.
    assign read    = (state == RD);
    assign rd_gnt  = (state == RD);
    assign rd_done = (state == RD);
    assign write   = (state == WR);
    assign wr_gnt  = (state == WR);
    assign busy    = (state != IDLE);

endmodule
